// File: rtl/out_uart_tx.sv
// Byte FIFO plus 8N1 UART serializer behind the CPU OUT register.
// Optional OUT_UART_PARITY_EN inserts an even-parity bit between data and stop.
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef OUT_UART_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            busy_q;
`ifdef OUT_UART_PARITY_EN
    logic            parity_q;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            full_q;
    logic            empty_q;
    logic            overflow_q;

    logic            bit_end_s;
    logic            push_s;
    logic            pop_s;
    logic [7:0]      head_s;

    // Pops happen from IDLE, or on the final stop cycle so frames chain without a gap.
    always_comb begin
        bit_end_s = (timer_q == T_LAST);
        push_s    = wr_en && !full_q;
        pop_s     = !empty_q && ((state_q == S_IDLE) ||
                                 ((state_q == S_STOP) && bit_end_s));
        head_s    = mem_q[rd_ptr_q];
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Frame FSM; tx_q is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef OUT_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop_s) begin
                        shift_q <= head_s;
`ifdef OUT_UART_PARITY_EN
                        parity_q <= ^head_s;
`endif
                        timer_q <= '0;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        timer_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`ifdef OUT_UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end_s) begin
                        timer_q <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end_s) begin
                        timer_q <= '0;
                        if (pop_s) begin
                            shift_q <= head_s;
`ifdef OUT_UART_PARITY_EN
                            parity_q <= ^head_s;
`endif
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx: stimulus queues expected bytes, a line monitor decodes frames.
module tb_out_uart_tx;

    localparam int C = 4;
    localparam int D = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx, busy, full, empty, overflow;
    logic [2:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .busy(busy), .full(full), .empty(empty),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(busy === 1'b0 && empty === 1'b1), 32'd1);
    endtask

    // Line monitor: any low level while out of reset is a start bit; every bit is
    // sampled on all C cycles so frame timing, not just content, is checked.
    initial begin : monitor
        logic [NB-1:0] bits;
        logic          stable;
        logic          aborted;
        logic [7:0]    got;
        logic [7:0]    want;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                stable  = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < NB; b++) begin
                    for (int j = 0; j < C; j++) begin
                        if (b != 0 || j != 0) @(negedge clk);
                        if (rst !== 1'b0) aborted = 1'b1;
                        if (j == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    got = bits[8:1];
                    chk("frame_shape", 32'({stable, bits[0], bits[NB-1]}), 32'b101);
`ifdef OUT_UART_PARITY_EN
                    chk("parity_bit", 32'(bits[9]), 32'(^got));
`endif
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %02h, want none", got);
                    end else begin
                        want = exp_q.pop_front();
                        chk("tx_byte", 32'(got), 32'(want));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   peak;
        logic busy_ok;
        logic quiet;

        // Reset held with a write attempt pending.
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        repeat (3) begin
            tick();
            chk("rst_state", 32'({tx, empty, count, overflow, busy}), 32'({1'b1, 1'b1, 3'd0, 1'b0, 1'b0}));
        end
        rst = 1'b0; wr_en = 1'b0;
        repeat (3) tick();

        // Single byte 0x41: latency and frame length.
        wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
        tick(); wr_en = 1'b0;
        chk("wr_latency", 32'({tx, busy, empty, count}), 32'({1'b1, 1'b0, 1'b0, 3'd1}));
        tick();
        chk("start_edge", 32'({tx, busy, empty, count}), 32'({1'b0, 1'b1, 1'b1, 3'd0}));
        repeat (FRAME - 1) tick();
        chk("busy_last", 32'(busy), 32'd1);
        tick();
        chk("busy_fall", 32'({busy, tx}), 32'b01);

        // Back-to-back 0x55, 0xAA.
        repeat (2) tick();
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        tick();
        peak = int'(count);
        wr_data = 8'hAA; exp_q.push_back(8'hAA);
        tick(); wr_en = 1'b0;
        if (int'(count) > peak) peak = int'(count);
        busy_ok = busy;
        for (int i = 1; i < 2 * FRAME; i++) begin
            tick();
            if (int'(count) > peak) peak = int'(count);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("b2b_peak", 32'(peak), 32'd1);
        chk("b2b_contig", 32'(busy_ok), 32'd1);
        tick();
        chk("b2b_end", 32'(busy), 32'd0);

        // Overflow: six writes into a four-deep queue.
        repeat (2) tick();
        for (int i = 1; i <= 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            tick();
            if (i == 5) chk("ovf_full", 32'({full, count, overflow}), 32'({1'b1, 3'd4, 1'b0}));
            if (i == 6) chk("ovf_drop", 32'({full, count, overflow}), 32'({1'b1, 3'd4, 1'b1}));
        end
        wr_en = 1'b0;
        wait_idle(8 * FRAME);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-frame during data bit 3.
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clr_ovf", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        tick(); wr_en = 1'b0;
        tick();
        repeat (4 * C + 1) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid", 32'({tx, count, busy, empty}), 32'({1'b1, 3'd0, 1'b0, 1'b1}));
        rst = 1'b0;
        exp_q.delete();
        quiet = 1'b1;
        repeat (3 * FRAME) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("no_frame_after_rst", 32'(quiet), 32'd1);

`ifdef OUT_UART_PARITY_EN
        // Parity frame for 0x07: parity bit 1, 44-cycle frame.
        wr_en = 1'b1; wr_data = 8'h07; exp_q.push_back(8'h07);
        tick(); wr_en = 1'b0;
        tick();
        chk("par_start", 32'({tx, busy}), 32'b01);
        repeat (9 * C) tick();
        chk("par_tx", 32'(tx), 32'd1);
        repeat (2 * C - 1) tick();
        chk("par_busy_last", 32'(busy), 32'd1);
        tick();
        chk("par_busy_fall", 32'(busy), 32'd0);
`endif

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Serial output port for the accumulator CPU. It sits directly downstream of the OUT register. Each cycle the CPU strobes an OUT write, the byte is captured into a small FIFO. The block then serializes the queued bytes onto an 8N1 UART line, so programs can emit characters without stalling on line rate.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be ≥ 2.
- FIFO_DEPTH, 4: byte slots in the queue; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; driven from the CPU's OUT control (ctrl_OUT).
- wr_data  in  8  byte to queue; driven from the accumulator output bus.
- tx  out  1  UART line; idles high.
- busy  out  1  high while a frame is being shifted (any state other than IDLE).
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- overflow  out  1  sticky; set when a write is dropped. Cleared only by rst.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values, applied at the clk edge with rst=1: tx=1, busy=0, full=0, empty=1, overflow=0, count=0, FSM=IDLE. FIFO pointers and the bit counter are zeroed.
- Reset during a frame: the frame is aborted, tx=1 from the next cycle, and queued bytes are discarded.
- FIFO write:
  - On a clk edge with wr_en=1 and full=0, wr_data is stored at the write pointer. The pointer then wraps modulo FIFO_DEPTH.
  - With wr_en=1 and full=1, the byte is dropped and overflow is set.
  - full is the registered value. A write and a pop in the same cycle while full still drops the write.
  - A write and a pop in the same cycle while not full leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop the head byte into the shift register, clear the bit timer, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - if empty=0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- The bit timer counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- Frame length is 10×CLKS_PER_BIT cycles.

## Timing
- Write latency:
  - wr_en is sampled at edge k, and count/empty update after edge k.
  - With the FSM in IDLE, the pop happens at edge k+1, and tx falls at edge k+1 (low starting cycle k+1 after the write edge).
  - busy rises at the same edge.
- tx is registered (glitch-free).
- Back-to-back bytes produce contiguous frames: the stop bit of byte N is immediately followed by the start bit of byte N+1.
- full/empty/count reflect the state after the most recent edge. The upstream CPU does not stall; software must pace writes or poll count.

## Configuration
- OUT_UART_PARITY_EN:
  - Defined: an even-parity bit is inserted between DATA and STOP. A PARITY state holds tx = XOR of the 8 data bits for CLKS_PER_BIT cycles. The frame is 11×CLKS_PER_BIT cycles.
  - Undefined: no PARITY state exists, the frame is 8N1, and the frame is 10×CLKS_PER_BIT cycles.

## Test plan
- Reset check: hold rst 3 cycles with wr_en=1, wr_data=8'hFF. Required: tx=1, empty=1, count=0, overflow=0, busy=0 throughout.
- Single byte (CLKS_PER_BIT=4): write 8'h41. Required: tx low for 4 cycles starting one cycle after the write edge, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then high for 4 cycles. busy falls after 40 cycles.
- Back-to-back: write 8'h55 then 8'hAA on consecutive cycles. Required: count peaks at 1, and 80 contiguous frame cycles with no idle high between stop and start.
- Overflow (FIFO_DEPTH=4): write 6 bytes 8'h01..8'h06 on consecutive cycles. Required:
  - first byte popped immediately, bytes 2–5 queued (full=1), byte 6 dropped, overflow=1;
  - transmitted sequence is 01,02,03,04,05.
- Reset mid-frame: write 8'h00, assert rst during DATA bit 3. Required: tx=1 the next cycle, count=0, and no further frame until a new write.
- Parity build (OUT_UART_PARITY_EN defined, CLKS_PER_BIT=4): write 8'h07. Required: parity bit = 1 after the data bits, and the frame is 44 cycles.
